// File: rtl/acc_pkg.sv
// Shared encodings and constants for the 8-bit accumulation stage.
package acc_pkg;

    localparam int ACC_W = 8;
    localparam logic [ACC_W-1:0] ACC_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Sticky overflow merge: once a carry has been seen it stays seen.
    function automatic logic ovf_merge(input logic ovf_prev, input logic carry);
        return ovf_prev | carry;
    endfunction

endpackage

// File: rtl/full_adder_8bits.sv
// 8-bit ripple-carry adder; purely combinational datapath for the accumulator.
module full_adder_8bits
    import acc_pkg::*;
(
    input  logic [ACC_W-1:0] n_1,
    input  logic [ACC_W-1:0] n_2,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    logic [ACC_W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_bit
        logic half;
        assign half         = n_1[i] ^ n_2[i];
        assign sum[i]       = half ^ carry[i];
        assign carry[i+1]   = (n_1[i] & n_2[i]) | (carry[i] & half);
    end

    assign cout = carry[ACC_W];

endmodule

// File: rtl/accumulator_8bits.sv
// Sums NUM_TERMS operands from a valid/ready stream and emits the total plus overflow.
// Optional ACC_SATURATE_EN: clamp the accumulator at 8'hFF after the first carry-out.
module accumulator_8bits
    import acc_pkg::*;
#(
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;
    logic             accept;
    logic             last_term;

    full_adder_8bits u_add (
        .n_1  (acc_q),
        .n_2  (in_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept    = in_valid && in_ready;
    assign last_term = (cnt_q == CNT_W'(NUM_TERMS - 1));
    assign ovf_nxt   = ovf_merge(ovf_q, add_cout);

`ifdef ACC_SATURATE_EN
    // ovf_q doubles as the "already saturated" flag: it is only ever set together with a clamp.
    assign acc_nxt = (ovf_q || add_cout) ? ACC_MAX : add_sum;
`else
    assign acc_nxt = add_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_nxt;
                        ovf_q <= ovf_nxt;
                        cnt_q <= cnt_q + CNT_W'(1);
                        // In IDLE cnt is 0, so this also covers NUM_TERMS == 1.
                        if (last_term) begin
                            state_q   <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_nxt;
                            out_ovf   <= ovf_nxt;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q   <= ST_IDLE;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_8bits.sv
// Self-checking bench for accumulator_8bits: vector table, corner sequences, randomized model check.
module tb_accumulator_8bits;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready;

    logic       clr1;
    logic [7:0] in_data1;
    logic       in_valid1;
    logic       in_ready1;
    logic [7:0] out_sum1;
    logic       out_ovf1;
    logic       out_valid1;
    logic       out_ready1;

    int n_pass;
    int n_total;

    accumulator_8bits #(.NUM_TERMS(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    accumulator_8bits #(.NUM_TERMS(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_sum(out_sum1), .out_ovf(out_ovf1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] ops;
        logic [7:0]      sum_wrap;
        logic [7:0]      sum_sat;
        logic            ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        sync();
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] pick(input vec_t v);
`ifdef ACC_SATURATE_EN
        return v.sum_sat;
`else
        return v.sum_wrap;
`endif
    endfunction

    // Reference model state: operand count, running total, sticky overflow, result pending.
    int m_cnt;
    int m_s;
    bit m_ovf;
    bit m_pend;

    task automatic model_clear();
        m_cnt = 0; m_s = 0; m_ovf = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input logic [7:0] d, input bit r);
        int ns;
        if (c) begin
            model_clear();
        end else if (m_pend) begin
            if (r) model_clear();
        end else if (v) begin
            ns = m_s + int'(d);
            if (ns > 255) m_ovf = 1;
`ifdef ACC_SATURATE_EN
            m_s = m_ovf ? 255 : ns;
`else
            m_s = ns % 256;
`endif
            m_cnt++;
            if (m_cnt == 4) m_pend = 1;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        clr1 = 1'b0; in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;

        vecs[0] = '{ {8'd40, 8'd30, 8'd20, 8'd10},      8'd100, 8'd100, 1'b0 };
        vecs[1] = '{ {8'd0, 8'd0, 8'd100, 8'd200},      8'd44,  8'd255, 1'b1 };
        vecs[2] = '{ {8'd0, 8'd0, 8'd1, 8'd255},        8'd0,   8'd255, 1'b1 };
        vecs[3] = '{ {8'd0, 8'd0, 8'd0, 8'd0},          8'd0,   8'd0,   1'b0 };
        vecs[4] = '{ {8'd0, 8'd0, 8'd0, 8'd255},        8'd255, 8'd255, 1'b0 };
        vecs[5] = '{ {8'd128, 8'd128, 8'd128, 8'd128},  8'd0,   8'd255, 1'b1 };
        vecs[6] = '{ {8'd0, 8'd55, 8'd100, 8'd100},     8'd255, 8'd255, 1'b0 };

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst1_in_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sync();

        // Vector table, back-to-back operands, out_ready tied high.
        foreach (vecs[i]) begin
            for (int k = 0; k < 4; k++) feed(vecs[i].ops[k]);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_sum", i),   32'(out_sum),   32'(pick(vecs[i])));
            chk($sformatf("vec%0d_ovf", i),   32'(out_ovf),   32'(vecs[i].ovf));
            chk($sformatf("vec%0d_rdy", i),   32'(in_ready),  32'd0);
            sync();
            chk($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_sum_zero", i),   32'(out_sum),   32'd0);
        end

        // Backpressure: DONE held for 5 cycles with in_valid asserted.
        out_ready = 1'b0;
        feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
        in_valid = 1'b1; in_data = 8'd99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum",   32'(out_sum),   32'd10);
            chk("bp_rdy",   32'(in_ready),  32'd0);
            sync();
        end
        out_ready = 1'b1;
        sync();
        chk("bp_idle_rdy",   32'(in_ready),  32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        sync();
        in_valid = 1'b0;
        feed(8'd1); feed(8'd1); feed(8'd1);
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_sum",   32'(out_sum),   32'd102);
        sync();

        // Asynchronous reset in the middle of a run.
        feed(8'd5); feed(8'd5);
        #3 rst = 1'b1;
        #1;
        chk("arst_mid_rdy",   32'(in_ready),  32'd1);
        chk("arst_mid_valid", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        sync();
        feed(8'd1); feed(8'd1); feed(8'd1); feed(8'd1);
        @(negedge clk);
        chk("arst_after_sum", 32'(out_sum), 32'd4);
        chk("arst_after_ovf", 32'(out_ovf), 32'd0);
        sync();

        // Asynchronous reset while a result is presented.
        out_ready = 1'b0;
        feed(8'd7); feed(8'd7); feed(8'd7); feed(8'd7);
        #2;
        chk("arst_done_pre", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_done_valid", 32'(out_valid), 32'd0);
        chk("arst_done_sum",   32'(out_sum),   32'd0);
        chk("arst_done_rdy",   32'(in_ready),  32'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        sync();

        // clr colliding with an accept drops the operand.
        feed(8'd50); feed(8'd60);
        clr = 1'b1; in_valid = 1'b1; in_data = 8'd7;
        @(negedge clk);
        chk("clr_col_rdy", 32'(in_ready), 32'd1);
        sync();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_after_rdy",   32'(in_ready),  32'd1);
        chk("clr_after_valid", 32'(out_valid), 32'd0);
        feed(8'd3); feed(8'd3); feed(8'd3); feed(8'd3);
        @(negedge clk);
        chk("clr_col_sum", 32'(out_sum), 32'd12);
        chk("clr_col_ovf", 32'(out_ovf), 32'd0);
        sync();

        // clr in DONE discards the result, with and without out_ready.
        out_ready = 1'b0;
        feed(8'd3); feed(8'd3); feed(8'd3); feed(8'd3);
        clr = 1'b1;
        sync();
        clr = 1'b0;
        chk("clr_done_valid", 32'(out_valid), 32'd0);
        chk("clr_done_sum",   32'(out_sum),   32'd0);
        feed(8'd3); feed(8'd3); feed(8'd3); feed(8'd3);
        clr = 1'b1; out_ready = 1'b1;
        sync();
        clr = 1'b0;
        chk("clr_done_rdy_valid", 32'(out_valid), 32'd0);
        chk("clr_done_rdy_in",    32'(in_ready),  32'd1);

        // NUM_TERMS=1 with gapped input.
        in_valid1 = 1'b1; in_data1 = 8'd9;
        sync();
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("gap_valid0", 32'(out_valid1), 32'd1);
        chk("gap_sum0",   32'(out_sum1),   32'd9);
        chk("gap_ovf0",   32'(out_ovf1),   32'd0);
        sync();
        chk("gap_rdy", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1; in_data1 = 8'd250;
        sync();
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("gap_valid1", 32'(out_valid1), 32'd1);
        chk("gap_sum1",   32'(out_sum1),   32'd250);
        chk("gap_ovf1",   32'(out_ovf1),   32'd0);
        sync();

        // Randomized traffic against the reference model.
        rst = 1'b1;
        #2 rst = 1'b0;
        model_clear();
        sync();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            chk("rnd_rdy",   32'(in_ready),  32'(!m_pend));
            chk("rnd_valid", 32'(out_valid), 32'(m_pend));
            chk("rnd_sum",   32'(out_sum),   m_pend ? 32'(m_s) : 32'd0);
            chk("rnd_ovf",   32'(out_ovf),   m_pend ? 32'(m_ovf) : 32'd0);
            @(posedge clk);
            model_step(clr, in_valid, in_data, out_ready);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
